// File: rtl/apb_master_n_pkg.sv
// apb_pkg: shared FSM state type and default address-map constants for the
// APB bridge master, its decoder, the interconnect and the linker map.
// Ports: none (package).
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam logic [31:0] APB_BASE_ADDR = 32'h1000_0000;
  localparam int          APB_SLOT_BITS = 12;

  // Width of a slave index; a single-slave bus still gets a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_master_n_if.sv
// apb_master_n_if: APB3 bus bundle between the bridge master and its slaves.
// Ports: none; signals PADDR/PWRITE/PENABLE/PWDATA/PSTRB/PSEL from master,
//        PRDATA (slave k at [k*DW +: DW]) / PREADY / PSLVERR from slaves.
interface apb_master_n_if #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int NSLV = 6
);

  logic [AW-1:0]      PADDR;
  logic               PWRITE;
  logic               PENABLE;
  logic [DW-1:0]      PWDATA;
  logic [DW/8-1:0]    PSTRB;
  logic [NSLV-1:0]    PSEL;
  logic [NSLV*DW-1:0] PRDATA;
  logic [NSLV-1:0]    PREADY;
  logic [NSLV-1:0]    PSLVERR;

  modport master (
    output PADDR, PWRITE, PENABLE, PWDATA, PSTRB, PSEL,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWRITE, PENABLE, PWDATA, PSTRB, PSEL,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_master_n_addr_decoder.sv
// apb_addr_decoder: combinational slot decode of a request address.
// Ports: addr (in, AW) -> idx (slot index), hit (slot index < NSLV).
// Addresses below BASE_ADDR wrap to a large offset and therefore miss.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int            AW        = 32,
  parameter int            NSLV      = 6,
  parameter logic [AW-1:0] BASE_ADDR = AW'(APB_BASE_ADDR),
  parameter int            SLOT_BITS = APB_SLOT_BITS
) (
  input  logic [AW-1:0]                addr,
  output logic [idx_width(NSLV)-1:0]   idx,
  output logic                         hit
);

  localparam int            OW        = AW - SLOT_BITS;
  localparam logic [OW-1:0] BASE_SLOT = BASE_ADDR[AW-1:SLOT_BITS];
  localparam logic [OW-1:0] NSLV_W    = OW'(NSLV);

  logic [OW-1:0] off;

  // Unsigned subtraction: modular wrap makes low addresses miss for free.
  assign off = addr[AW-1:SLOT_BITS] - BASE_SLOT;
  assign hit = (off < NSLV_W);
  assign idx = off[idx_width(NSLV)-1:0];

endmodule

// File: rtl/apb_master_n.sv
// apb_master_n: APB3 bridge master from the core load/store path, NSLV slaves.
// Ports: PCLK/PRESET (async, active-high); apb (master modport of the bus);
//        core side transfer/write/addr/wdata/strb in, ready/rdata/err/busy out.
// Optional PREADY watchdog compiled in with `define APB_MASTER_TIMEOUT_EN.
module apb_master_n
  import apb_pkg::*;
#(
  parameter int            AW        = 32,
  parameter int            DW        = 32,
  parameter int            NSLV      = 6,
  parameter logic [AW-1:0] BASE_ADDR = AW'(APB_BASE_ADDR),
  parameter int            SLOT_BITS = APB_SLOT_BITS,
  parameter int            TIMEOUT   = 255
) (
  input  logic            PCLK,
  input  logic            PRESET,
  apb_master_n_if.master  apb,
  input  logic            transfer,
  input  logic            write,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] strb,
  output logic            ready,
  output logic [DW-1:0]   rdata,
  output logic            err,
  output logic            busy
);

  localparam int IW = idx_width(NSLV);
  localparam int SW = DW / 8;

  apb_state_t      state_q, state_d;
  logic [AW-1:0]   paddr_q;
  logic            pwrite_q;
  logic [DW-1:0]   pwdata_q;
  logic [SW-1:0]   pstrb_q;
  logic [IW-1:0]   idx_q;
  logic            hit_q;

  logic [IW-1:0]   dec_idx;
  logic            dec_hit;
  logic            req_ld;
  logic            sel_rdy;
  logic            done;
  logic            tmo_hit;
  logic            tmo;

  apb_addr_decoder #(
    .AW        (AW),
    .NSLV      (NSLV),
    .BASE_ADDR (BASE_ADDR),
    .SLOT_BITS (SLOT_BITS)
  ) u_dec (
    .addr (addr),
    .idx  (dec_idx),
    .hit  (dec_hit)
  );

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 255) ? 16 : 8;
  logic [CW-1:0] cnt_q;

  assign tmo = (cnt_q == CW'(TIMEOUT));

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cnt_q <= '0;
    end else if (state_q == SETUP) begin
      cnt_q <= '0;
    end else if (state_q == ACCESS && !sel_rdy && !tmo) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  logic tmo_unused;
  assign tmo_unused = (TIMEOUT != 0);
  assign tmo        = 1'b0;
`endif

  // An unmapped request has no slave to wait on; it completes immediately.
  assign sel_rdy = hit_q ? apb.PREADY[idx_q] : 1'b1;

  always_comb begin
    state_d = state_q;
    req_ld  = 1'b0;
    done    = 1'b0;
    tmo_hit = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (transfer) begin
          req_ld  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (sel_rdy) begin
          done = 1'b1;
          if (transfer) begin
            req_ld  = 1'b1;
            state_d = SETUP;
          end else begin
            state_d = IDLE;
          end
        end else if (tmo) begin
          // Forced abort always returns to IDLE; a pending request is retried.
          done    = 1'b1;
          tmo_hit = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready = done;
    err   = done && (!hit_q || tmo_hit || apb.PSLVERR[idx_q]);
    rdata = '0;
    if (done && hit_q && !pwrite_q && !tmo_hit) rdata = apb.PRDATA[idx_q*DW +: DW];
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      idx_q    <= '0;
      hit_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (req_ld) begin
        paddr_q  <= addr;
        pwrite_q <= write;
        pwdata_q <= wdata;
        pstrb_q  <= write ? strb : '0;
        idx_q    <= dec_idx;
        hit_q    <= dec_hit;
      end
    end
  end

  // Bus select/enable come from registers only so slaves never see core glitches.
  always_comb begin
    apb.PSEL = '0;
    if (state_q != IDLE && hit_q) apb.PSEL[idx_q] = 1'b1;
  end

  assign apb.PENABLE = (state_q == ACCESS);
  assign apb.PADDR   = paddr_q;
  assign apb.PWRITE  = pwrite_q;
  assign apb.PWDATA  = pwdata_q;
  assign apb.PSTRB   = pstrb_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: doc/apb_master_n.md
# apb_master_n

Parametrised APB3 bridge master between the RISC-V core's load/store path and the peripheral bus. It generalises the six-slave fixed-map master:
- slave count, data width and address-slot size are parameters;
- adds PSTRB, PSLVERR propagation, an error response for unmapped addresses, back-to-back transfers and an optional PREADY watchdog.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width (multiple of 8)
- NSLV, 6, number of slaves (1..16)
- BASE_ADDR, 32'h1000_0000, address of slave 0 slot
- SLOT_BITS, 12, log2 of per-slave slot size (slave k at BASE_ADDR + k<<SLOT_BITS)
- TIMEOUT, 255, max ACCESS wait cycles (only with watchdog compiled in)

Ports:
- PCLK  in  1  APB clock
- PRESET  in  1  reset, asynchronous, active-high
- PADDR  out  AW  registered request address
- PWRITE  out  1  1 = write
- PENABLE  out  1  high in ACCESS only
- PWDATA  out  DW  write data
- PSTRB  out  DW/8  byte strobes (forced 0 on reads)
- PSEL  out  NSLV  one-hot select
- PRDATA  in  NSLV*DW  slave k read data at [k*DW +: DW]
- PREADY  in  NSLV  per-slave ready
- PSLVERR  in  NSLV  per-slave error
- transfer  in  1  request strobe from core
- write  in  1  request direction
- addr  in  AW  request address
- wdata  in  DW  request write data
- strb  in  DW/8  request byte enables
- ready  out  1  one-cycle completion pulse
- rdata  out  DW  read data, valid with ready
- err  out  1  error flag, valid with ready
- busy  out  1  state != IDLE

## Operation
- FSM IDLE -> SETUP -> ACCESS.
  - IDLE: transfer=1 latches write/addr/wdata/strb (PSTRB=0 if read) and decodes the slave index into a registered idx/hit. Next state SETUP.
  - SETUP: PSEL[idx]=hit, PENABLE=0. Next state ACCESS unconditionally.
  - ACCESS: PSEL held, PENABLE=1. Completes when PREADY[idx]=1.
- On completion:
  - ready=1, rdata=PRDATA[idx] (0 on writes), err=PSLVERR[idx].
  - If transfer=1 in the same cycle, latch the new request and go to SETUP (back-to-back, no IDLE bubble); otherwise go to IDLE.
- transfer is ignored in SETUP and in non-completing ACCESS cycles. The core must hold it until ready or busy=0.
- Decode:
  - off = addr[AW-1:SLOT_BITS] - BASE_ADDR[AW-1:SLOT_BITS], unsigned.
  - hit = off < NSLV; idx = off.
  - Addresses below BASE_ADDR wrap to a huge off and are therefore a miss.
- Miss (unmapped):
  - SETUP/ACCESS run with PSEL all-zero.
  - Completes in the first ACCESS cycle with ready=1, err=1, rdata=0.
- Outside a completion cycle: ready=0, err=0, rdata=0.
- PSEL/PENABLE are driven from state and registers only, never from core inputs. PADDR/PWRITE/PWDATA/PSTRB hold their last values in IDLE.

## Timing
- Reset values: PADDR=0, PWRITE=0, PENABLE=0, PWDATA=0, PSTRB=0, PSEL=0, ready=0, rdata=0, err=0, busy=0, state IDLE, watchdog count 0.
- Latency: transfer at cycle N, SETUP at N+1, ACCESS at N+2. With zero-wait slaves, ready at N+2.
- Each wait state adds one cycle.
- Back-to-back throughput: 2 cycles per transfer.
- ready/rdata/err are combinational from PREADY/PRDATA/PSLVERR in ACCESS. The core samples them on the same edge.
- PRESET mid-transfer: PSEL/PENABLE drop immediately (async). No ready is issued for the aborted transfer.

## Configuration
- Macro APB_MASTER_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter clears on SETUP and increments each ACCESS cycle with PREADY[idx]=0.
  - When the counter reaches TIMEOUT, the transfer is forced to complete: ready=1, err=1, rdata=0, next state IDLE.
  - The transfer is forced to IDLE even if transfer=1; the back-to-back request is dropped and the core retries.
  - If PREADY arrives in the same cycle the count reaches TIMEOUT, PREADY wins: normal completion.
- Undefined: no counter; ACCESS waits indefinitely.

## Structure
- Package apb_pkg holds:
  - typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;
  - default constants APB_BASE_ADDR and APB_SLOT_BITS, shared with the interconnect and the linker map.
- Sub-module apb_addr_decoder (parameters AW, NSLV, BASE_ADDR, SLOT_BITS; in addr; out idx, hit) is combinational and instantiated once on the latch path.
- Read mux and ready mux are indexed part-selects inline; no separate mux module.

## Test plan
- Write 0x1000_2004 = 0xDEAD_BEEF, strb=4'hF, slave 2 zero-wait -> PSEL=6'b000100 at N+1, PENABLE at N+2, ready at N+2, err=0.
- Read 0x1000_5010, slave 5 with 3 wait states returning 0x1234_5678 -> ready at N+5, rdata=0x1234_5678, PSTRB=0.
- Read 0x1000_7000 (unmapped, NSLV=6) -> PSEL stays 0, ready at N+2, err=1, rdata=0; same for 0x0FFF_F000.
- Two requests back-to-back (write slave 0, then read slave 1) with transfer held -> second SETUP directly follows first completion; two ready pulses 2 cycles apart.
- Slave 3 asserts PSLVERR with PREADY -> err=1 on that ready only.
- With APB_MASTER_TIMEOUT_EN and TIMEOUT=4, slave never ready -> ready=1, err=1 after 4 ACCESS cycles, then IDLE; PRESET asserted in ACCESS -> all outputs 0 asynchronously.
